uart_tx_arbiter: RTL and testbench

Shares one PISO UART transmitter among NUM_REQ byte requesters. Round-robin arbitration picks a requester and latches its byte. The block computes the parity bit, pulses send into the transmitter, then tracks its active/done flags to completion. After each frame it enforces a programmable inter-frame idle gap before the next grant. It sits between host-side byte producers and the transmitter top, on the same baud clock.

---
 rtl/uart_tx_arb_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types, defaults and the parity helper for the UART transmitter arbiter.
// Optional timeout logic in uart_tx_arbiter is enabled by UART_TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    WAIT_ACTIVE = 3'd2,
    WAIT_DONE   = 3'd3,
    GAP         = 3'd4
  } state_t;

  localparam int GAP_CYC_DEF     = 1;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int PAR_MAX_W       = 64;

  // Callers zero-extend narrower bytes; extra zeros do not change the XOR.
  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set request searching upward from ptr+1,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_any
);

  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // Priority search starting just past the last winner.
  always_comb begin
    win_oh     = '0;
    win_idx    = '0;
    win_any    = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s     = (int'(ptr) + i) % NUM_REQ;
      cand_idx_s = IDX_W'(cand_s);
      if (!win_any && req[cand_idx_s]) begin
        win_any             = 1'b1;
        win_oh[cand_idx_s]  = 1'b1;
        win_idx             = cand_idx_s;
      end else begin
        win_any = win_any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one PISO UART transmitter among NUM_REQ byte requesters.
// Define UART_TX_ARB_TIMEOUT_EN to add the WAIT_ACTIVE/WAIT_DONE timeout with err pulse.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int PARITY_ODD  = 0,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      baud_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      err,
  output logic                      tx_send,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_parity,
  input  logic                      tx_active_flag,
  input  logic                      tx_done_flag
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam state_t           POST_FRAME = (GAP_CYC == 0) ? IDLE : GAP;

  state_t                  state_r, state_nxt_s;
  logic [IDX_W-1:0]        ptr_r, ptr_nxt_s;
  logic [IDX_W-1:0]        cur_idx_r, cur_idx_nxt_s;
  logic [GAP_W-1:0]        gap_cnt_r, gap_cnt_nxt_s;
  logic [NUM_REQ-1:0]      gnt_r, gnt_nxt_s;
  logic [NUM_REQ-1:0]      done_r, done_nxt_s;
  logic                    busy_r, busy_nxt_s;
  logic                    err_r, err_nxt_s;
  logic                    tx_send_r, tx_send_nxt_s;
  logic [DATA_W-1:0]       tx_data_r, tx_data_nxt_s;
  logic                    tx_parity_r, tx_parity_nxt_s;

  logic [NUM_REQ-1:0]      win_oh_s;
  logic [IDX_W-1:0]        win_idx_s;
  logic                    win_any_s;
  logic [DATA_W-1:0]       win_data_s;
  logic [PAR_MAX_W-1:0]    par_in_s;
  logic                    par_s;
  logic                    in_wait_s;
  logic                    complete_s;
  logic                    timeout_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_r),
    .win_oh  (win_oh_s),
    .win_idx (win_idx_s),
    .win_any (win_any_s)
  );

  assign win_data_s = req_data[win_idx_s*DATA_W +: DATA_W];
  assign par_s      = calc_parity(par_in_s, PARITY_ODD != 0);
  assign in_wait_s  = (state_r == WAIT_ACTIVE) || (state_r == WAIT_DONE);

  // Zero-extend the winning byte for the shared parity helper.
  always_comb begin
    par_in_s               = '0;
    par_in_s[DATA_W-1:0]   = win_data_s;
  end

  // Transmitter done is completion from either wait state.
  always_comb begin
    if (in_wait_s) begin
      complete_s = tx_done_flag;
    end else begin
      complete_s = 1'b0;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;

  // Completion on the final cycle wins over the timeout.
  assign timeout_s = in_wait_s && !complete_s && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // Cycles spent waiting on the transmitter for the current frame.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (in_wait_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
  assign timeout_s        = 1'b0;
`endif

  // State register.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_any_s) state_nxt_s = LOAD;
        else           state_nxt_s = IDLE;
      end
      LOAD: state_nxt_s = WAIT_ACTIVE;
      WAIT_ACTIVE: begin
        if (complete_s || timeout_s) state_nxt_s = POST_FRAME;
        else if (tx_active_flag)     state_nxt_s = WAIT_DONE;
        else                         state_nxt_s = WAIT_ACTIVE;
      end
      WAIT_DONE: begin
        if (complete_s || timeout_s) state_nxt_s = POST_FRAME;
        else                         state_nxt_s = WAIT_DONE;
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) state_nxt_s = IDLE;
        else                       state_nxt_s = GAP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    gnt_nxt_s       = '0;
    done_nxt_s      = '0;
    err_nxt_s       = 1'b0;
    tx_send_nxt_s   = 1'b0;
    tx_data_nxt_s   = tx_data_r;
    tx_parity_nxt_s = tx_parity_r;
    ptr_nxt_s       = ptr_r;
    cur_idx_nxt_s   = cur_idx_r;
    gap_cnt_nxt_s   = '0;
    busy_nxt_s      = (state_nxt_s != IDLE);
    case (state_r)
      IDLE: begin
        if (win_any_s) begin
          gnt_nxt_s       = win_oh_s;
          tx_send_nxt_s   = 1'b1;
          tx_data_nxt_s   = win_data_s;
          tx_parity_nxt_s = par_s;
          ptr_nxt_s       = win_idx_s;
          cur_idx_nxt_s   = win_idx_s;
        end else begin
          gnt_nxt_s = '0;
        end
      end
      WAIT_ACTIVE, WAIT_DONE: begin
        if (complete_s) begin
          done_nxt_s[cur_idx_r] = 1'b1;
        end else if (timeout_s) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) gap_cnt_nxt_s = '0;
        else                       gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
      end
      default: gap_cnt_nxt_s = '0;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= '0;
      done_r      <= '0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      tx_send_r   <= 1'b0;
      tx_data_r   <= '0;
      tx_parity_r <= 1'b0;
      ptr_r       <= PTR_RST;
      cur_idx_r   <= '0;
      gap_cnt_r   <= '0;
    end else begin
      gnt_r       <= gnt_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
      err_r       <= err_nxt_s;
      tx_send_r   <= tx_send_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      tx_parity_r <= tx_parity_nxt_s;
      ptr_r       <= ptr_nxt_s;
      cur_idx_r   <= cur_idx_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign tx_send   = tx_send_r;
  assign tx_data   = tx_data_r;
  assign tx_parity = tx_parity_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (even-parity DUT plus an odd-parity twin).
module tb_uart_tx_arbiter;

  logic        baud_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_active_flag;
  logic        tx_done_flag;

  logic [3:0]  gnt, done;
  logic        busy, err, tx_send, tx_parity;
  logic [7:0]  tx_data;
  logic [3:0]  gnt_o, done_o;
  logic        busy_o, err_o, tx_send_o, tx_parity_o;
  logic [7:0]  tx_data_o;

  int checks = 0;
  int errors = 0;

  always #5 baud_clk = ~baud_clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .PARITY_ODD(0), .GAP_CYC(1), .TIMEOUT_CYC(64)) dut (
    .baud_clk(baud_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .busy(busy), .err(err),
    .tx_send(tx_send), .tx_data(tx_data), .tx_parity(tx_parity),
    .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .PARITY_ODD(1), .GAP_CYC(1), .TIMEOUT_CYC(64)) dut_odd (
    .baud_clk(baud_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt_o), .done(done_o), .busy(busy_o), .err(err_o),
    .tx_send(tx_send_o), .tx_data(tx_data_o), .tx_parity(tx_parity_o),
    .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag)
  );

  task automatic step();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From the grant edge: LOAD, active, done, gap -> back in IDLE.
  task automatic frame_tail();
    step();
    tx_active_flag = 1'b1;
    step();
    tx_active_flag = 1'b0;
    tx_done_flag   = 1'b1;
    step();
    tx_done_flag   = 1'b0;
    step();
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [7:0] exp_b;
    logic       err_seen;

    rst_n = 1'b0; req = 4'd0; req_data = 32'd0;
    tx_active_flag = 1'b0; tx_done_flag = 1'b0;
    repeat (3) step();
    chk("rst_gnt", gnt, 4'd0);
    chk("rst_done", done, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_send", tx_send, 1'b0);
    chk("rst_data", tx_data, 8'd0);
    chk("rst_par", tx_parity, 1'b0);
    rst_n = 1'b1;

    // Single request, 0xA5
    req = 4'b0001; req_data = 32'h0000_00A5;
    step();
    chk("a5_gnt", gnt, 4'b0001);
    chk("a5_send", tx_send, 1'b1);
    chk("a5_data", tx_data, 8'hA5);
    chk("a5_par_even", tx_parity, 1'b0);
    chk("a5_par_odd", tx_parity_o, 1'b1);
    chk("a5_busy", busy, 1'b1);
    req = 4'b0000;
    step();
    chk("a5_load_gnt", gnt, 4'd0);
    chk("a5_load_send", tx_send, 1'b0);
    chk("a5_hold_data", tx_data, 8'hA5);
    tx_active_flag = 1'b1;
    step();
    chk("a5_wa_done", done, 4'd0);
    chk("a5_wa_busy", busy, 1'b1);
    tx_active_flag = 1'b0; tx_done_flag = 1'b1;
    step();
    chk("a5_done", done, 4'b0001);
    chk("a5_gap_busy", busy, 1'b1);
    tx_done_flag = 1'b0;
    step();
    chk("a5_done_clr", done, 4'd0);
    chk("a5_busy_fall", busy, 1'b0);

    // Byte 0x01 parity on requester 2
    req = 4'b0100; req_data = 32'h0001_0000;
    step();
    chk("p01_gnt", gnt, 4'b0100);
    chk("p01_data", tx_data, 8'h01);
    chk("p01_par_even", tx_parity, 1'b1);
    chk("p01_par_odd", tx_parity_o, 1'b0);
    req = 4'b0000;
    frame_tail();

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Full load: round-robin 0,1,2,3,0
    req = 4'b1111; req_data = 32'h4433_2211;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_b = 8'h11 + 8'h11 * 8'(k % 4);
      step();
      chk("rr_gnt", gnt, exp_g);
      chk("rr_data", tx_data, exp_b);
      chk("rr_send", tx_send, 1'b1);
      step();
      chk("rr_send_low", tx_send, 1'b0);
      tx_active_flag = 1'b1;
      step();
      tx_active_flag = 1'b0; tx_done_flag = 1'b1;
      step();
      tx_done_flag = 1'b0;
      chk("rr_done", done, exp_g);
      step();
      chk("rr_gap_nognt", gnt, 4'd0);
      chk("rr_gap_nosend", tx_send, 1'b0);
    end

    // req[2] raised then dropped during requester 1's WAIT_DONE
    req = 4'b0010;
    step();
    chk("drop_gnt1", gnt, 4'b0010);
    req = 4'b0000;
    step();
    tx_active_flag = 1'b1;
    step();
    tx_active_flag = 1'b0;
    req = 4'b1100;
    step();
    chk("drop_wd_gnt", gnt, 4'd0);
    req = 4'b1000;
    step();
    chk("drop_wd_gnt2", gnt, 4'd0);
    tx_done_flag = 1'b1;
    step();
    tx_done_flag = 1'b0;
    chk("drop_done1", done, 4'b0010);
    step();
    chk("drop_gap_gnt", gnt, 4'd0);
    step();
    chk("drop_gnt3", gnt, 4'b1000);
    chk("drop_data3", tx_data, 8'h44);

    // Reset in WAIT_DONE
    req = 4'b0000;
    step();
    tx_active_flag = 1'b1;
    step();
    tx_active_flag = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt", gnt, 4'd0);
    chk("mrst_done", done, 4'd0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_err", err, 1'b0);
    chk("mrst_send", tx_send, 1'b0);
    chk("mrst_data", tx_data, 8'd0);
    chk("mrst_par", tx_parity, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_nodone", done, 4'd0);
    chk("mrst_idle", busy, 1'b0);
    req = 4'b0010;
    step();
    chk("mrst_gnt1", gnt, 4'b0010);
    req = 4'b0000;
    frame_tail();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b0011;
    step();
    chk("mrst_gnt0_first", gnt, 4'b0001);

    // Done flag seen directly in WAIT_ACTIVE
    req = 4'b0000;
    step();
    tx_done_flag = 1'b1;
    step();
    tx_done_flag = 1'b0;
    chk("fast_done", done, 4'b0001);
    step();
    chk("fast_idle", busy, 1'b0);

    // Transmitter never goes active
    req = 4'b0001;
    step();
    chk("to_gnt", gnt, 4'b0001);
    req = 4'b0000;
    step();
    err_seen = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      step();
`ifdef UART_TX_ARB_TIMEOUT_EN
      chk("to_err", err, (k == 64) ? 1'b1 : 1'b0);
      chk("to_nodone", done, 4'd0);
`else
      err_seen = err_seen | err | (|done);
`endif
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    chk("to_busy_end", busy, 1'b0);
`else
    chk("to_err_never", err_seen, 1'b0);
    chk("to_busy_stuck", busy, 1'b1);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
